// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, oversampling constants and
// the legal stop-length tick counts used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int START_MID  = 7;

    // s_tick periods spent in the stop state for 1, 1.5 and 2 stop bits
    localparam int SB_TICK_1   = 16;
    localparam int SB_TICK_1P5 = 24;
    localparam int SB_TICK_2   = 32;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Both flops reset high so an idle-high line never looks asserted after reset.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/uart_rx_sampler.sv
// 16x oversampling UART receiver: start-bit qualification at mid-bit, LSB-first
// data assembly, stop-bit check, registered word/flag with a one-cycle done strobe.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = SB_TICK_1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err
);

    rx_state_t       state_reg, state_next;
    logic [4:0]      s_reg, s_next;
    logic [2:0]      n_reg, n_next;
    logic [DBIT-1:0] shift_reg, shift_next;
    logic [DBIT-1:0] dout_reg, dout_next;
    logic            ferr_reg, ferr_next;
    logic            done_reg, done_next;
    logic            rx_s;

    sync_2ff u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            s_reg     <= '0;
            n_reg     <= '0;
            shift_reg <= '0;
            dout_reg  <= '0;
            ferr_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            shift_reg <= shift_next;
            dout_reg  <= dout_next;
            ferr_reg  <= ferr_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        shift_next = shift_reg;
        dout_next  = dout_reg;
        ferr_next  = ferr_reg;
        done_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                // Start detection is not tick-qualified; a coincident tick is not counted.
                if (!rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_reg == 5'(START_MID)) begin
                        if (!rx_s) begin
                            state_next = DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_reg == 5'(OVERSAMPLE - 1)) begin
                        s_next     = '0;
                        shift_next = {rx_s, shift_reg[DBIT-1:1]};
                        if (n_reg == 3'(DBIT - 1)) begin
                            state_next = STOP;
                        end else begin
                            n_next = n_reg + 3'd1;
                        end
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_reg == 5'(SB_TICK - 1)) begin
                        state_next = IDLE;
                        dout_next  = shift_reg;
                        ferr_next  = ~rx_s;
                        done_next  = 1'b1;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign dout         = dout_reg;
    assign frame_err    = ferr_reg;
    assign rx_done_tick = done_reg;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: 8N1 frames at 64 clk per bit with a
// tick every 4 clk, covering glitches, framing errors, back-to-back frames, reset and tick freeze.
module tb_uart_rx_sampler;

    localparam int BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       s_tick;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;

    logic       tick_en = 1'b1;
    int         tick_cnt;
    int         total = 0;
    int         bad = 0;
    logic [7:0] pulse_dout[$];
    logic       pulse_ferr[$];

    always #5 clk = ~clk;

    uart_rx_sampler #(
        .DBIT    (8),
        .SB_TICK (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .s_tick       (s_tick),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err)
    );

    // Baud tick source: one pulse every 4 clk, maskable to freeze the receiver.
    initial begin : tick_gen
        s_tick   = 1'b0;
        tick_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            tick_cnt = (tick_cnt + 1) % 4;
            s_tick   = tick_en && (tick_cnt == 0);
        end
    end

    always @(negedge clk) begin
        if (rx_done_tick) begin
            pulse_dout.push_back(dout);
            pulse_ferr.push_back(frame_err);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: got=%0h", tag, got);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int len);
        rx = b;
        wait_clk(len);
    endtask

    // stop_low_clk > 0 holds the stop bit low for that many clk, past its mid-bit sample
    task automatic send_frame(input logic [7:0] data, input int stop_low_clk, input int gap_clk);
        send_bit(1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) send_bit(data[i], BIT_CLK);
        if (stop_low_clk > 0) begin
            send_bit(1'b0, stop_low_clk);
            send_bit(1'b1, BIT_CLK - stop_low_clk);
        end else begin
            send_bit(1'b1, BIT_CLK);
        end
        if (gap_clk > 0) send_bit(1'b1, gap_clk);
    endtask

    function automatic int pulses_since(input int n0);
        return pulse_dout.size() - n0;
    endfunction

    initial begin : main
        int         n0;
        logic [7:0] d0, d1;
        logic       f0, f1;
        logic [7:0] frz;

        reset = 1'b1;
        rx    = 1'b1;
        wait_clk(3);
        check("reset_dout", 32'(dout), 32'h0);
        check("reset_done", 32'(rx_done_tick), 32'h0);
        check("reset_ferr", 32'(frame_err), 32'h0);
        reset = 1'b0;
        wait_clk(10);

        // Clean 8N1 frame
        n0 = pulse_dout.size();
        send_frame(8'hA5, 0, 64);
        check("a5_pulses", 32'(pulses_since(n0)), 32'd1);
        check("a5_dout", 32'(dout), 32'hA5);
        check("a5_ferr", 32'(frame_err), 32'h0);

        // Short low glitch must be rejected at mid start bit
        n0 = pulse_dout.size();
        send_bit(1'b0, 12);
        send_bit(1'b1, 100);
        check("glitch_pulses", 32'(pulses_since(n0)), 32'd0);
        check("glitch_dout", 32'(dout), 32'hA5);

        // Stop bit low -> framing error, then a good frame clears it
        n0 = pulse_dout.size();
        send_frame(8'h3C, 44, 64);
        check("3c_pulses", 32'(pulses_since(n0)), 32'd1);
        check("3c_dout", 32'(dout), 32'h3C);
        check("3c_ferr", 32'(frame_err), 32'h1);
        send_frame(8'h81, 0, 64);
        check("81_dout", 32'(dout), 32'h81);
        check("81_ferr", 32'(frame_err), 32'h0);

        // Back-to-back frames, no idle gap
        n0 = pulse_dout.size();
        send_frame(8'h00, 0, 0);
        send_frame(8'hFF, 0, 64);
        check("b2b_pulses", 32'(pulses_since(n0)), 32'd2);
        d0 = (pulse_dout.size() > n0)     ? pulse_dout[n0]     : 8'hxx;
        f0 = (pulse_ferr.size() > n0)     ? pulse_ferr[n0]     : 1'bx;
        d1 = (pulse_dout.size() > n0 + 1) ? pulse_dout[n0 + 1] : 8'hxx;
        f1 = (pulse_ferr.size() > n0 + 1) ? pulse_ferr[n0 + 1] : 1'bx;
        check("b2b_dout0", 32'(d0), 32'h00);
        check("b2b_ferr0", 32'(f0), 32'h0);
        check("b2b_dout1", 32'(d1), 32'hFF);
        check("b2b_ferr1", 32'(f1), 32'h0);

        // Reset during data bit 4 of 0x77
        n0 = pulse_dout.size();
        send_bit(1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) send_bit(1'(8'h77 >> i), BIT_CLK);
        rx = 1'b1;
        wait_clk(20);
        reset = 1'b1;
        #1;
        check("rst_mid_dout", 32'(dout), 32'h0);
        check("rst_mid_done", 32'(rx_done_tick), 32'h0);
        wait_clk(2);
        reset = 1'b0;
        rx    = 1'b1;
        wait_clk(800);
        check("rst_mid_pulses", 32'(pulses_since(n0)), 32'd0);
        n0 = pulse_dout.size();
        send_frame(8'h5A, 0, 64);
        check("5a_pulses", 32'(pulses_since(n0)), 32'd1);
        check("5a_dout", 32'(dout), 32'h5A);

        // Tick freeze for 200 clk inside data bit 3 while rx toggles
        frz = 8'hC3;
        n0  = pulse_dout.size();
        send_bit(1'b0, BIT_CLK);
        for (int i = 0; i < 3; i++) send_bit(frz[i], BIT_CLK);
        rx = frz[3];
        wait_clk(16);
        tick_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rx = ~rx;
            wait_clk(10);
        end
        check("frz_pulses_hold", 32'(pulses_since(n0)), 32'd0);
        rx      = frz[3];
        tick_en = 1'b1;
        wait_clk(BIT_CLK - 16);
        for (int i = 4; i < 8; i++) send_bit(frz[i], BIT_CLK);
        send_bit(1'b1, BIT_CLK);
        send_bit(1'b1, 64);
        check("frz_pulses", 32'(pulses_since(n0)), 32'd1);
        check("frz_dout", 32'(dout), 32'hC3);
        check("frz_ferr", 32'(frame_err), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
